// File: rtl/i2c_ascii_decoder.sv
// i2c_ascii_decoder
//   Passive I2C bus monitor. Samples raw SCL/SDA, filters them, detects
//   START / repeated START / STOP and data bytes with ACK/NAK, queues each
//   as a timestamped event, then prints every event as ASCII text on a
//   valid/ready byte stream (typically a UART TX FIFO).
//
//   Optional build macro: I2C_DELTA_TS_EN
//     defined   - START timestamps print as the difference from the previous
//                 printed START timestamp (first one after reset is absolute)
//     undefined - START timestamps print as the absolute sampled value
//
// Ports
//   i_clk, i_res_n      clock; synchronous active-low reset
//   i_i2c_scl/sda       raw asynchronous bus lines
//   i_timestamp         free-running timestamp, captured on START detect
//   i_ts_en             1 = prefix START lines with TS_WIDTH/4 hex digits
//   i_ovf_clr           pulse: clear o_ovf and o_drop_cnt
//   o_valid/o_data      ASCII output byte, held while i_ready is low
//   i_ready             downstream accepts o_data
//   o_ovf               sticky: an event was dropped on a full queue
//   o_drop_cnt          dropped-event count, saturating at 255
//   o_busy              queue not empty or emitter not idle
module i2c_ascii_decoder #(
  parameter int TS_WIDTH  = 32,
  parameter int GF_LEN    = 4,
  parameter int EVQ_DEPTH = 4
) (
  input  logic                i_clk,
  input  logic                i_res_n,
  input  logic                i_i2c_scl,
  input  logic                i_i2c_sda,
  input  logic [TS_WIDTH-1:0] i_timestamp,
  input  logic                i_ts_en,
  input  logic                i_ovf_clr,
  output logic                o_valid,
  output logic [7:0]          o_data,
  input  logic                i_ready,
  output logic                o_ovf,
  output logic [7:0]          o_drop_cnt,
  output logic                o_busy
);

  localparam int ND    = TS_WIDTH / 4;
  localparam int GC_W  = $clog2(GF_LEN);
  localparam int AW    = $clog2(EVQ_DEPTH);
  localparam int IDX_W = $clog2(ND + 6);

  typedef enum logic [1:0] {EV_START, EV_STOP, EV_BYTE} ev_kind_e;

  typedef struct packed {
    ev_kind_e            kind;
    logic                rep;
    logic [7:0]          data;
    logic                nak;
    logic [TS_WIDTH-1:0] ts;
  } event_t;

  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_TS_DIG, ST_TXT, ST_DONE} state_e;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // ---------------- input path: sync, glitch filter, edge stage -----------
  // Bit 0 carries SCL, bit 1 carries SDA.
  logic [1:0]      pin_m, pin_s, filt, filt_d;
  logic [GC_W-1:0] gf_cnt [2];

  // NOTE: every clocked process uses non-blocking assignments so all
  // registers update together from the values present before the edge.
  always_ff @(posedge i_clk) begin
    if (!i_res_n) begin
      pin_m  <= 2'b11;
      pin_s  <= 2'b11;
      filt   <= 2'b11;
      filt_d <= 2'b11;
      for (int i = 0; i < 2; i++) gf_cnt[i] <= '0;
    end else begin
      pin_m  <= {i_i2c_sda, i_i2c_scl};
      pin_s  <= pin_m;
      filt_d <= filt;
      // The filtered line flips only after GF_LEN consecutive samples that
      // disagree with it; any agreeing sample restarts the run.
      for (int i = 0; i < 2; i++) begin
        if (pin_s[i] == filt[i]) begin
          gf_cnt[i] <= '0;
        end else if (gf_cnt[i] == GC_W'(GF_LEN - 1)) begin
          filt[i]   <= pin_s[i];
          gf_cnt[i] <= '0;
        end else begin
          gf_cnt[i] <= gf_cnt[i] + 1'b1;
        end
      end
    end
  end

  logic scl_f, sda_f, scl_d, sda_d;
  logic start_det, stop_det, scl_rise;
  assign {sda_f, scl_f} = filt;
  assign {sda_d, scl_d} = filt_d;
  assign start_det = scl_f & scl_d & sda_d & ~sda_f;
  assign stop_det  = scl_f & scl_d & ~sda_d & sda_f;
  assign scl_rise  = scl_f & ~scl_d;

  // ---------------- bus protocol tracking ---------------------------------
  logic       in_frame;
  logic [3:0] bit_cnt;
  logic [7:0] shreg;

  always_ff @(posedge i_clk) begin
    if (!i_res_n) begin
      in_frame <= 1'b0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else if (start_det) begin
      in_frame <= 1'b1;
      bit_cnt  <= '0;
    end else if (stop_det) begin
      in_frame <= 1'b0;
      bit_cnt  <= '0;
    end else if (scl_rise && in_frame) begin
      shreg   <= {shreg[6:0], sda_f};
      bit_cnt <= (bit_cnt == 4'd8) ? 4'd0 : bit_cnt + 4'd1;
    end
  end

  logic   push;
  event_t push_ev;

  // NOTE: combinational blocks assign every output a default first so no
  // path leaves a variable unassigned (which would infer a latch).
  always_comb begin
    push    = 1'b0;
    push_ev = '0;
    push_ev.ts = i_timestamp;
    if (start_det) begin
      push         = 1'b1;
      push_ev.kind = EV_START;
      push_ev.rep  = in_frame;
    end else if (stop_det) begin
      push         = 1'b1;
      push_ev.kind = EV_STOP;
    end else if (scl_rise && in_frame && bit_cnt == 4'd8) begin
      push         = 1'b1;
      push_ev.kind = EV_BYTE;
      push_ev.data = shreg;
      push_ev.nak  = sda_f;   // ninth bit is the ACK slot
    end
  end

  // ---------------- event queue -------------------------------------------
  event_t      mem [EVQ_DEPTH];
  event_t      head;
  logic [AW:0] wr_ptr, rd_ptr;
  logic        q_empty, q_full, drop;
  state_e      state, state_nx;

  assign q_empty = (wr_ptr == rd_ptr);
  assign q_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign drop    = push & q_full;
  assign head    = mem[rd_ptr[AW-1:0]];

  // NOTE: queue storage has no reset; the pointers alone define which
  // entries are meaningful.
  always_ff @(posedge i_clk) begin
    if (push && !q_full) mem[wr_ptr[AW-1:0]] <= push_ev;
  end

  always_ff @(posedge i_clk) begin
    if (!i_res_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_ovf      <= 1'b0;
      o_drop_cnt <= '0;
    end else begin
      if (push && !q_full) wr_ptr <= wr_ptr + 1'b1;
      if (state == ST_LOAD) rd_ptr <= rd_ptr + 1'b1;
      // A clear coinciding with a drop still records that drop.
      if (i_ovf_clr) begin
        o_ovf      <= drop;
        o_drop_cnt <= {7'd0, drop};
      end else if (drop) begin
        o_ovf <= 1'b1;
        if (o_drop_cnt != 8'hFF) o_drop_cnt <= o_drop_cnt + 8'd1;
      end
    end
  end

  // ---------------- emitter -----------------------------------------------
  ev_kind_e            cur_kind;
  logic                cur_rep, cur_nak;
  logic [7:0]          cur_data;
  logic [TS_WIDTH-1:0] ts_sh, ts_print;
  logic [IDX_W-1:0]    idx;

`ifdef I2C_DELTA_TS_EN
  logic [TS_WIDTH-1:0] last_ts;
  assign ts_print = head.ts - last_ts;
`else
  assign ts_print = head.ts;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_res_n) begin
      state    <= ST_IDLE;
      idx      <= '0;
      ts_sh    <= '0;
      cur_kind <= EV_START;
      cur_rep  <= 1'b0;
      cur_nak  <= 1'b0;
      cur_data <= '0;
`ifdef I2C_DELTA_TS_EN
      last_ts  <= '0;
`endif
    end else begin
      state <= state_nx;
      case (state)
        ST_LOAD: begin
          cur_kind <= head.kind;
          cur_rep  <= head.rep;
          cur_nak  <= head.nak;
          cur_data <= head.data;
          ts_sh    <= ts_print;
          idx      <= '0;
`ifdef I2C_DELTA_TS_EN
          if (head.kind == EV_START && i_ts_en) last_ts <= head.ts;
`endif
        end
        ST_TS_DIG: if (i_ready) begin
          if (idx == IDX_W'(ND)) begin
            idx <= '0;
          end else begin
            idx   <= idx + 1'b1;
            ts_sh <= ts_sh << 4;
          end
        end
        ST_TXT: if (i_ready) idx <= idx + 1'b1;
        default: ;
      endcase
    end
  end

  // Character at position idx of the event text, and the last position.
  logic [7:0] txt_char;
  logic [2:0] txt_last_i;

  always_comb begin
    txt_char   = 8'h20;
    txt_last_i = 3'd0;
    case (cur_kind)
      EV_START: begin
        txt_last_i = cur_rep ? 3'd2 : 3'd1;
        if (idx[2:0] == 3'd0)                 txt_char = 8'h53;   // 'S'
        else if (idx[2:0] == 3'd1 && cur_rep) txt_char = 8'h72;   // 'r'
      end
      EV_BYTE: begin
        txt_last_i = 3'd4;
        case (idx[2:0])
          3'd0:    txt_char = hex_char(cur_data[7:4]);
          3'd1:    txt_char = hex_char(cur_data[3:0]);
          3'd3:    txt_char = cur_nak ? 8'h4E : 8'h41;            // 'N' / 'A'
          default: txt_char = 8'h20;
        endcase
      end
      default: begin                                              // STOP
        txt_last_i = 3'd2;
        case (idx[2:0])
          3'd0:    txt_char = 8'h50;                              // 'P'
          3'd1:    txt_char = 8'h0D;
          default: txt_char = 8'h0A;
        endcase
      end
    endcase
  end

  always_comb begin
    state_nx = state;
    o_valid  = 1'b0;
    o_data   = 8'h00;
    case (state)
      ST_IDLE:   if (!q_empty) state_nx = ST_LOAD;
      ST_LOAD:   state_nx = (head.kind == EV_START && i_ts_en) ? ST_TS_DIG : ST_TXT;
      ST_TS_DIG: begin
        o_valid = 1'b1;
        o_data  = (idx == IDX_W'(ND)) ? 8'h20 : hex_char(ts_sh[TS_WIDTH-1 -: 4]);
        if (i_ready && idx == IDX_W'(ND)) state_nx = ST_TXT;
      end
      ST_TXT: begin
        o_valid = 1'b1;
        o_data  = txt_char;
        if (i_ready && idx == IDX_W'(txt_last_i)) state_nx = ST_DONE;
      end
      ST_DONE:   state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  assign o_busy = !q_empty || (state != ST_IDLE);

endmodule

// File: tb/tb_i2c_ascii_decoder.sv
// Testbench for i2c_ascii_decoder: drives I2C traffic on SCL/SDA, pushes
// the expected ASCII bytes into a scoreboard queue as each bus event is
// driven, and compares against every byte accepted on the output stream.
module tb_i2c_ascii_decoder;

  localparam int TS_WIDTH  = 32;
  localparam int GF_LEN    = 4;
  localparam int EVQ_DEPTH = 4;
  localparam int ND        = TS_WIDTH / 4;
  localparam int H         = 12;   // cycles per I2C phase, well above filter latency

  logic                i_clk = 1'b0;
  logic                i_res_n, i_i2c_scl, i_i2c_sda, i_ts_en, i_ovf_clr, i_ready;
  logic [TS_WIDTH-1:0] i_timestamp;
  logic                o_valid, o_ovf, o_busy;
  logic [7:0]          o_data, o_drop_cnt;

  always #5 i_clk = ~i_clk;

  i2c_ascii_decoder #(
    .TS_WIDTH(TS_WIDTH), .GF_LEN(GF_LEN), .EVQ_DEPTH(EVQ_DEPTH)
  ) dut (
    .i_clk(i_clk), .i_res_n(i_res_n),
    .i_i2c_scl(i_i2c_scl), .i_i2c_sda(i_i2c_sda),
    .i_timestamp(i_timestamp), .i_ts_en(i_ts_en), .i_ovf_clr(i_ovf_clr),
    .o_valid(o_valid), .o_data(o_data), .i_ready(i_ready),
    .o_ovf(o_ovf), .o_drop_cnt(o_drop_cnt), .o_busy(o_busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard and output monitor -------------------------
  logic [7:0]          exp_q[$];
  logic [TS_WIDTH-1:0] last_ts = '0;
  int                  hold_viol = 0;
  int                  extra_cnt = 0;
  logic                busy_seen = 1'b0;
  logic                prev_stall = 1'b0;
  logic [7:0]          prev_data = '0;
  logic                rand_ready = 1'b0;

  always @(negedge i_clk) begin
    if (!i_res_n) begin
      prev_stall = 1'b0;
    end else begin
      if (o_busy) busy_seen = 1'b1;
      if (prev_stall && (!o_valid || o_data !== prev_data)) hold_viol++;
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) extra_cnt++;
        else check("byte", o_data, exp_q.pop_front());
      end
      prev_stall = o_valid && !i_ready;
      prev_data  = o_data;
    end
  end

  always begin
    @(posedge i_clk);
    #1;
    if (rand_ready) i_ready = 1'($urandom_range(0, 1));
  end

  function automatic logic [7:0] hex(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + 8'(n) : 8'h41 + 8'(n) - 8'd10;
  endfunction

  task automatic push_str(input logic [127:0] s, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(s[(n-1-i)*8 +: 8]);
  endtask

  task automatic exp_start(input logic rep);
    logic [TS_WIDTH-1:0] v;
    if (i_ts_en) begin
`ifdef I2C_DELTA_TS_EN
      v = i_timestamp - last_ts;
`else
      v = i_timestamp;
`endif
      last_ts = i_timestamp;
      for (int i = ND - 1; i >= 0; i--) exp_q.push_back(hex(v[i*4 +: 4]));
      exp_q.push_back(8'h20);
    end
    exp_q.push_back(8'h53);
    if (rep) exp_q.push_back(8'h72);
    exp_q.push_back(8'h20);
  endtask

  task automatic exp_byte(input logic [7:0] b, input logic nak);
    exp_q.push_back(hex(b[7:4]));
    exp_q.push_back(hex(b[3:0]));
    exp_q.push_back(8'h20);
    exp_q.push_back(nak ? 8'h4E : 8'h41);
    exp_q.push_back(8'h20);
  endtask

  task automatic exp_stop();
    push_str(128'h500D0A, 3);
  endtask

  // ---------------- bus drivers -------------------------------------------
  task automatic cyc(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic i2c_start();     // from idle bus
    i2c_sda_set(1'b0); cyc(H);
    i_i2c_scl = 1'b0;  cyc(H);
  endtask

  task automatic i2c_rep_start(); // from SCL low inside a frame
    i2c_sda_set(1'b1); cyc(H);
    i_i2c_scl = 1'b1;  cyc(H);
    i2c_sda_set(1'b0); cyc(H);
    i_i2c_scl = 1'b0;  cyc(H);
  endtask

  task automatic i2c_bit(input logic b);
    i2c_sda_set(b);   cyc(H);
    i_i2c_scl = 1'b1; cyc(H);
    i_i2c_scl = 1'b0; cyc(H);
  endtask

  task automatic i2c_byte(input logic [7:0] b, input logic nak);
    for (int i = 7; i >= 0; i--) i2c_bit(b[i]);
    i2c_bit(nak);
  endtask

  task automatic i2c_stop();
    i2c_sda_set(1'b0); cyc(H);
    i_i2c_scl = 1'b1;  cyc(H);
    i2c_sda_set(1'b1); cyc(H);
  endtask

  task automatic i2c_sda_set(input logic v);
    i_i2c_sda = v;
  endtask

  task automatic do_reset();
    i_res_n = 1'b0;
    cyc(3);
    exp_q.delete();
    last_ts = '0;
    i_res_n = 1'b1;
    cyc(4);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || o_busy) && n < 3000) begin
      @(negedge i_clk);
      n++;
    end
    check(tag, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------------------------------------
  initial begin
    logic [7:0] b;
    logic       nk;
    int         kept, n;

    i_res_n = 1'b0; i_i2c_scl = 1'b1; i_i2c_sda = 1'b1;
    i_ts_en = 1'b0; i_ovf_clr = 1'b0; i_ready = 1'b1; i_timestamp = '0;
    cyc(3);
    check("rst_valid", o_valid, 0);
    check("rst_data",  o_data, 8'h00);
    check("rst_busy",  o_busy, 0);
    check("rst_ovf",   o_ovf, 0);
    check("rst_drop",  o_drop_cnt, 0);
    i_res_n = 1'b1;
    cyc(10);

    // Two ACKed writes then STOP, no timestamps.
    push_str(128'h532041302041204135204120500D0A, 15);
    i2c_start();
    i2c_byte(8'hA0, 1'b0);
    i2c_byte(8'hA5, 1'b0);
    i2c_stop();
    wait_idle("t1_left");

    // Timestamped START line.
    i_ts_en = 1'b1; i_timestamp = 32'h0012ABCD;
    push_str(128'h3030313241424344205320, 11);
    last_ts = i_timestamp;
    i2c_start();
    exp_stop();
    i2c_stop();
    wait_idle("t2_left");
    i_ts_en = 1'b0;

    // Repeated START and a NAKed byte.
    push_str(128'h5320, 2);             i2c_start();
    push_str(128'h4130204120, 5);       i2c_byte(8'hA0, 1'b0);
    push_str(128'h537220, 3);           i2c_rep_start();
    push_str(128'h4131204E20, 5);       i2c_byte(8'hA1, 1'b1);
    push_str(128'h500D0A, 3);           i2c_stop();
    wait_idle("t3_left");

    // SDA glitches shorter than the filter length while SCL is high.
    busy_seen = 1'b0;
    for (int len = 1; len < GF_LEN; len++) begin
      i_i2c_sda = 1'b0; cyc(len);
      i_i2c_sda = 1'b1; cyc(20);
    end
    check("glitch_busy", busy_seen, 0);

    // Reset in the middle of an event truncates the output.
    i_ready = 1'b0;
    i2c_start();
    i2c_stop();
    n = 0;
    while (!o_valid && n < 200) begin @(negedge i_clk); n++; end
    check("mid_valid", o_valid, 1);
    check("mid_data",  o_data, 8'h53);
    cyc(1);
    i_res_n = 1'b0;
    cyc(2);
    check("mid_rst_valid", o_valid, 0);
    check("mid_rst_busy",  o_busy, 0);
    exp_q.delete();
    last_ts = '0;
    i_res_n = 1'b1;
    i_ready = 1'b1;
    cyc(30);
    check("mid_no_resume", o_busy, 0);

    // Overflow with the output stalled: emitter holds one event, the queue
    // EVQ_DEPTH more, the rest are dropped.
    i_ready = 1'b0;
    hold_viol = 0;
    kept = 0;
    for (int k = 0; k < 5; k++) begin
      if (kept < EVQ_DEPTH + 1) begin exp_start(1'b0); kept++; end
      i2c_start();
      if (kept < EVQ_DEPTH + 1) begin exp_stop(); kept++; end
      i2c_stop();
    end
    cyc(20);
    check("ovf_set",    o_ovf, 1);
    check("drop_cnt",   o_drop_cnt, 10 - EVQ_DEPTH - 1);
    check("stall_data", o_data, 8'h53);
    check("stall_hold", hold_viol, 0);
    i_ovf_clr = 1'b1; cyc(1);
    i_ovf_clr = 1'b0; cyc(1);
    check("ovf_clr",  o_ovf, 0);
    check("drop_clr", o_drop_cnt, 0);
    i_ready = 1'b1;
    wait_idle("t6_left");

    // Timestamp deltas between printed STARTs.
    do_reset();
    i_ts_en = 1'b1;
    i_timestamp = 32'h100; exp_start(1'b0); i2c_start(); exp_stop(); i2c_stop();
    i_timestamp = 32'h350; exp_start(1'b0); i2c_start(); exp_stop(); i2c_stop();
    wait_idle("t7_left");

    // Random bytes with random back-pressure.
    rand_ready = 1'b1;
    hold_viol = 0;
    i_timestamp = $urandom;
    exp_start(1'b0); i2c_start();
    for (int k = 0; k < 4; k++) begin
      b = 8'($urandom); nk = 1'($urandom_range(0, 1));
      exp_byte(b, nk); i2c_byte(b, nk);
    end
    i_timestamp = $urandom;
    exp_start(1'b1); i2c_rep_start();
    for (int k = 0; k < 2; k++) begin
      b = 8'($urandom); nk = 1'($urandom_range(0, 1));
      exp_byte(b, nk); i2c_byte(b, nk);
    end
    exp_stop(); i2c_stop();
    cyc(200);
    rand_ready = 1'b0;
    i_ready = 1'b1;
    wait_idle("t8_left");
    check("rand_hold", hold_viol, 0);
    check("rand_ovf",  o_ovf, 0);

    cyc(10);
    check("extra_bytes", extra_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule
